// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers and MTHI/MTLO write port.
// Latency: start sampled at E0, hi/lo loaded at E32, done pulses E32..E33 (divide-by-zero: done one cycle after E0).
// Backpressure: none; start is ignored outside IDLE and MTHI/MTLO writes are ignored during CALC.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   a_reg;      // |A|: multiplicand
    logic [WIDTH-1:0]   b_reg;      // |B|: divisor
    logic [2*WIDTH-1:0] prod;       // multiply accumulator, low half starts as the multiplier
    logic [WIDTH-1:0]   rem;        // divide partial remainder
    logic [WIDTH-1:0]   quo;        // dividend shifting out, quotient shifting in
    logic               is_div;
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder

    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes for signed ops; raw operands for unsigned ops
    always_comb begin
        rs_abs = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_abs = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    // One shift-add step and one restoring-divide step, plus sign-corrected results of the final step
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_reg} : '0);
        prod_nxt  = {mul_sum, prod[WIDTH-1:1]};
        prod_fix  = neg_q ? -prod_nxt : prod_nxt;
        // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
        // and a successful subtraction always leaves a WIDTH-bit result.
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        rem_nxt   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_nxt   = {quo[WIDTH-2:0], div_ge};
        quo_fix   = neg_q ? -quo_nxt : quo_nxt;
        rem_fix   = neg_r ? -rem_nxt : rem_nxt;
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        if (op[1] && (rt_data == '0)) begin
                            // Divide by zero: skip the datapath, leave hi/lo alone
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            count  <= '0;
                            a_reg  <= rs_abs;
                            b_reg  <= rt_abs;
                            prod   <= {{WIDTH{1'b0}}, rt_abs};
                            rem    <= '0;
                            quo    <= rs_abs;
                            is_div <= op[1];
                            neg_q  <= op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            neg_r  <= op[0] & rs_data[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    prod  <= prod_nxt;
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    // A write here lands after the result and overwrites it
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed literal checks.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: stimulus includes start/MTHI/MTLO during CALC and mid-operation reset.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Behavioural model state
    logic [W-1:0] m_hi, m_lo;
    logic         m_busy, m_done, m_dbz;
    int           m_left;        // edges remaining until the pending result lands
    logic [63:0]  m_pend;        // {hi, lo} of the running operation

    // MIPS result from plain arithmetic: {hi, lo}
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0:    r = {32'b0, a} * {32'b0, b};
            2'd1:    r = 64'(sa * sb);
            2'd2:    r = {a % b, a / b};
            default: r = {32'(sa % sb), 32'(sa / sb)};
        endcase
        return r;
    endfunction

    task automatic model_edge();
        bit was_done;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0; m_left = 0;
        end else begin
            was_done = m_done;
            m_done = 0;
            m_dbz  = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1;
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start && !was_done) begin
                    if (op[1] && rt_data == 0) begin
                        m_done = 1;
                        m_dbz  = 1;
                    end else begin
                        m_pend = ref_result(op, rs_data, rt_data);
                        m_left = W;
                    end
                end
            end
        end
        m_busy = (m_left > 0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, got, exp);
        end
    endtask

    // One clock: advance model with the inputs present at the edge, then compare all outputs
    task automatic cyc();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        check("busy",        32'(busy),        32'(m_busy));
        check("done",        32'(done),        32'(m_done));
        check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        check("hi",          hi,               m_hi);
        check("lo",          lo,               m_lo);
    endtask

    // Launch one op and run until done (bounded); returns start-to-done cycle count
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        cyc();
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            cyc();
            lat++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_op_timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n_done;
        int rises[$];
        logic prev_busy;

        rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dbz = 0; m_left = 0; m_pend = '0;
        cyc();
        cyc();
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        rst = 1'b0;
        cyc();

        // MULTU max * max
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_latency", 32'(lat), 32'd33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        cyc();

        // MULT -3 * 7
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        cyc();

        // DIV -7 / 2
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        cyc();

        // DIVU 100 / 7
        run_op(2'd2, 32'd100, 32'd7, lat);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        cyc();

        // Preload HI/LO, then divide by zero
        hi_we = 1'b1; wdata = 32'h11;
        cyc();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        cyc();
        lo_we = 1'b0;
        run_op(2'd2, 32'd5, 32'd0, lat);
        check("dbz_latency", 32'(lat), 32'd1);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        check("dbz_hi", hi, 32'h11);
        check("dbz_lo", lo, 32'h22);
        cyc();

        // MULTU 3*5 with start and MTLO attempted mid-operation
        op = 2'd0; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        start = 1'b1; lo_we = 1'b1; wdata = 32'hAA; op = 2'd2; rt_data = 32'd0;
        cyc();
        start = 1'b0; lo_we = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin cyc(); lat++; end
        check("midop_done_seen", 32'(done), 32'd1);
        check("midop_lo", lo, 32'd15);
        check("midop_hi", hi, 32'd0);
        cyc();

        // Reset in the middle of a MULTU
        op = 2'd0; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 19; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin cyc(); if (done === 1'b1) n_done++; end
        check("rst_mid_no_done", 32'(n_done), 32'd0);

        // start held high: launches every 34 cycles
        start = 1'b1; op = 2'd0;
        prev_busy = busy;
        for (int i = 0; i < 120 && rises.size() < 3; i++) begin
            op = 2'($urandom_range(3)); rs_data = rand_word(); rt_data = $urandom | 32'h1;
            cyc();
            if (busy === 1'b1 && prev_busy !== 1'b1) rises.push_back(cycle);
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_launches", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("b2b_gap1", 32'(rises[1] - rises[0]), 32'd34);
            check("b2b_gap2", 32'(rises[2] - rises[1]), 32'd34);
        end
        for (int i = 0; i < 36; i++) cyc();

        // Signed overflow divide
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        check("ovf_flag", 32'(div_by_zero), 32'd0);
        cyc();

        // Randomized traffic, including MTHI/MTLO in DONE and with start, and occasional reset
        for (int i = 0; i < 6000; i++) begin
            start   = ($urandom_range(2) == 0);
            op      = 2'($urandom_range(3));
            rs_data = rand_word();
            rt_data = ($urandom_range(7) == 0) ? 32'h0 : rand_word();
            hi_we   = ($urandom_range(5) == 0);
            lo_we   = ($urandom_range(5) == 0);
            wdata   = $urandom;
            rst     = ($urandom_range(499) == 0);
            cyc();
        end
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        for (int i = 0; i < 40; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
